full_adder_reg: RTL and testbench
=================================

Name: full_adder_reg

Overview:
- Registered ripple-carry full adder: adds two WIDTH-bit operands and a 1-bit carry-in.
- Produces a WIDTH-bit sum, carry-out and signed-overflow flag through one output register stage.
- With WIDTH=1 it is the classic single-bit full adder, registered for clean timing.
- Used as a leaf arithmetic element inside datapaths on a single clock domain.

Parameters:
- WIDTH, 1, operand/sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- c  input  1  carry-in.
- valid_i  input  1  qualifies a/b/c this cycle.
- sum  output  WIDTH  registered sum, {cout,sum} = a + b + c.
- cout  output  1  registered carry-out of the MSB.
- ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- valid_o  output  1  registered copy of valid_i.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset:
  - Asserting rst_n low immediately (no clock needed) forces sum=0, cout=0, ovf=0, valid_o=0.
  - Outputs stay at these values while rst_n is low.
  - First capture happens on the first rising clk edge after rst_n goes high.
- Per-bit logic (bit i):
  - s_i = a_i ^ b_i ^ k_i
  - k_(i+1) = (a_i & b_i) | (a_i & k_i) | (b_i & k_i)
  - k_0 = c; cout = k_WIDTH
  - Implemented as a generate loop of single-bit full-adder cells (ripple chain).
- Overflow:
  - ovf = k_WIDTH ^ k_(WIDTH-1).
  - For WIDTH=1: ovf = cout ^ c.
- Latency: exactly 1 cycle. Values on a/b/c at rising edge N appear on sum/cout/ovf after edge N.
- valid_o follows valid_i with the same 1-cycle latency.
- When valid_i=0, sum/cout/ovf hold their previous values (register enable = valid_i); valid_o goes 0.
- No back-pressure. A new operation is accepted every cycle valid_i=1; throughput is 1 result per cycle.
- X/Z on operands while valid_i=0 must not propagate to the outputs.
- Reset mid-operation: an in-flight result is discarded and valid_o=0 after release. The next result requires a new valid_i.
- Wrap-around: all-ones + all-ones + 1 gives sum=all-ones, cout=1. Results are modulo 2^WIDTH, carry reported separately.
- No latches. Combinational logic is confined to the adder chain; all outputs come directly from flops.

Test Plan:
- Reset: drive rst_n=0 asynchronously between clock edges with valid_i=1, a=b=c=1 -> sum, cout, ovf, valid_o all 0 immediately, without waiting for clk.
- WIDTH=1 exhaustive: all 8 combinations of a,b,c with valid_i=1 -> one cycle later {cout,sum} equals 00,01,01,10,01,10,10,11 for abc=000..111; ovf=cout^c.
- WIDTH=8 carry/wrap:
  - a=8'hFF, b=8'h01, c=0 -> sum=8'h00, cout=1, ovf=0.
  - a=8'hFF, b=8'hFF, c=1 -> sum=8'hFF, cout=1.
- WIDTH=8 signed overflow:
  - a=8'h7F, b=8'h01, c=0 -> sum=8'h80, cout=0, ovf=1.
  - a=8'h80, b=8'h80, c=0 -> sum=8'h00, cout=1, ovf=1.
- Hold and valid:
  - Load a=3, b=4, c=1 with valid_i=1 -> sum=8.
  - Then valid_i=0 with a=X, b=X for 3 cycles -> sum stays 8, valid_o=0.
- Random: 20 back-to-back random a/b/c vectors with valid_i=1 -> every cycle {cout,sum} matches a+b+c from the previous cycle, valid_o=1 continuously.

Source files
------------

// File: rtl/full_adder_reg.sv
// ---------------------------------------------------------------------------
// full_adder_reg
//   Registered ripple-carry adder: {cout,sum} = a + b + c, with a signed
//   overflow flag, all presented from one output register stage.
//   With WIDTH=1 this is the classic single-bit full adder, registered.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   a        in   WIDTH  operand A (unsigned or two's complement)
//   b        in   WIDTH  operand B
//   c        in   1      carry-in
//   valid_i  in   1      qualifies a/b/c this cycle
//   sum      out  WIDTH  registered sum (modulo 2^WIDTH)
//   cout     out  1      registered carry-out of the MSB
//   ovf      out  1      registered signed overflow
//   valid_o  out  1      registered copy of valid_i
//
// Latency is one cycle. When valid_i is low the result registers hold their
// contents, so undefined operands in idle cycles never reach the outputs.
// ---------------------------------------------------------------------------

// Single-bit full-adder cell used as one link of the ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic k_in,
  output logic s,
  output logic k_out
);

  assign s     = a ^ b ^ k_in;
  assign k_out = (a & b) | (a & k_in) | (b & k_in);

endmodule

module full_adder_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             valid_i,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             valid_o
);

  // Signed overflow occurs exactly when the carry entering the MSB differs
  // from the carry leaving it.
  function automatic logic signed_ovf(input logic k_msb_in,
                                      input logic k_msb_out);
    return k_msb_in ^ k_msb_out;
  endfunction

  logic [WIDTH:0]   k_p0;
  logic [WIDTH-1:0] sum_p0;
  logic             ovf_p0;

  logic [WIDTH-1:0] sum_p1;
  logic             cout_p1;
  logic             ovf_p1;
  logic             vld_p1;

  // Stage p0: combinational ripple chain, carry k_p0[0] is the carry-in.
  assign k_p0[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .k_in  (k_p0[i]),
      .s     (sum_p0[i]),
      .k_out (k_p0[i+1])
    );
  end

  // For WIDTH=1 the carry into the MSB is the carry-in itself.
  assign ovf_p0 = signed_ovf(k_p0[WIDTH-1], k_p0[WIDTH]);

  // Stage p1: output registers. Result registers load only on valid_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
    end else if (valid_i) begin
      sum_p1  <= sum_p0;
      cout_p1 <= k_p0[WIDTH];
      ovf_p1  <= ovf_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= valid_i;
    end
  end

  assign sum     = sum_p1;
  assign cout    = cout_p1;
  assign ovf     = ovf_p1;
  assign valid_o = vld_p1;

endmodule

// File: tb/tb_full_adder_reg.sv
// ---------------------------------------------------------------------------
// tb_full_adder_reg
//   Drives a WIDTH=8 and a WIDTH=1 instance in lockstep. The driver pushes the
//   expected next-cycle outputs of both instances into a queue; a monitor
//   pops one entry after every rising edge and compares.
// ---------------------------------------------------------------------------
module tb_full_adder_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       c;
  logic       valid_i;

  logic [7:0] sum8;
  logic       cout8, ovf8, valid_o8;
  logic [0:0] sum1;
  logic       cout1, ovf1, valid_o1;

  always #5 clk = ~clk;

  full_adder_reg #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a8),
    .b       (b8),
    .c       (c),
    .valid_i (valid_i),
    .sum     (sum8),
    .cout    (cout8),
    .ovf     (ovf8),
    .valid_o (valid_o8)
  );

  full_adder_reg #(.WIDTH(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a1),
    .b       (b1),
    .c       (c),
    .valid_i (valid_i),
    .sum     (sum1),
    .cout    (cout1),
    .ovf     (ovf1),
    .valid_o (valid_o1)
  );

  typedef struct {
    logic       v;
    logic [7:0] s8;
    logic       co8;
    logic       ov8;
    logic       s1;
    logic       co1;
    logic       ov1;
  } exp_t;

  exp_t exp_q[$];
  exp_t held;          // model of the result registers (reset to zero)
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Reference: integer arithmetic on the operand values. Overflow is the
  // true signed sum (carry-in counted as +1) falling outside the range.
  function automatic exp_t model(input exp_t prev, input logic [7:0] a,
                                 input logic [7:0] b, input logic cin,
                                 input logic v);
    exp_t e;
    int unsigned u;
    int sgn;
    e = prev;
    e.v = v;
    if (v) begin
      u      = int'(a) + int'(b) + int'(cin);
      e.s8   = u[7:0];
      e.co8  = (u > 255);
      sgn    = int'($signed(a)) + int'($signed(b)) + int'(cin);
      e.ov8  = (sgn > 127) || (sgn < -128);
      u      = int'(a[0]) + int'(b[0]) + int'(cin);
      e.s1   = u[0];
      e.co1  = (u > 1);
      sgn    = (a[0] ? -1 : 0) + (b[0] ? -1 : 0) + int'(cin);
      e.ov1  = (sgn > 0) || (sgn < -1);
    end
    return e;
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic v);
    @(negedge clk);
    a8      = a;
    b8      = b;
    a1      = a[0:0];
    b1      = b[0:0];
    c       = cin;
    valid_i = v;
    held    = model(held, a, b, cin, v);
    exp_q.push_back(held);
  endtask

  // Monitor: one expected entry per driven cycle, checked after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("w8 {valid,cout,ovf,sum}", {valid_o8, cout8, ovf8, sum8},
            {e.v, e.co8, e.ov8, e.s8});
        chk("w1 {valid,cout,ovf,sum}", {valid_o1, cout1, ovf1, sum1},
            {e.v, e.co1, e.ov1, e.s1});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    held    = '{default: 1'b0};
    rst_n   = 1'b0;
    valid_i = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; a1 = 1'b1; b1 = 1'b1; c = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset w8", {valid_o8, cout8, ovf8, sum8}, 11'h0);
    chk("reset w1", {valid_o1, cout1, ovf1, sum1}, 4'h0);
    valid_i = 1'b0;
    rst_n   = 1'b1;

    // Exhaustive single-bit combinations (abc = 000..111).
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      drive({7'b0, abc[2]}, {7'b0, abc[1]}, abc[0], 1'b1);
    end

    // Carry, wrap-around and signed overflow corners.
    drive(8'hFF, 8'h01, 1'b0, 1'b1);
    drive(8'hFF, 8'hFF, 1'b1, 1'b1);
    drive(8'h7F, 8'h01, 1'b0, 1'b1);
    drive(8'h80, 8'h80, 1'b0, 1'b1);

    // Hold while idle with undefined operands.
    drive(8'd3, 8'd4, 1'b1, 1'b1);
    repeat (3) drive('x, 'x, 1'b0, 1'b0);

    // Back-to-back random traffic.
    for (int i = 0; i < 20; i++)
      drive(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    drive(8'h00, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset between edges while a result is held.
    drive(8'hFF, 8'hFF, 1'b1, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async reset w8", {valid_o8, cout8, ovf8, sum8}, 11'h0);
    chk("async reset w1", {valid_o1, cout1, ovf1, sum1}, 4'h0);
    @(negedge clk);
    valid_i = 1'b0;
    rst_n   = 1'b1;
    held    = '{default: 1'b0};

    drive(8'h55, 8'hAA, 1'b1, 1'b0);
    drive(8'h12, 8'h34, 1'b0, 1'b1);
    drive(8'h00, 8'h00, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
